// File: rtl/dcim_stream_sequencer.sv
// Host-side sequencer for sram_multiplier_system: streams weight-load and compute operands
// into the macro and collects results into a credit-protected FIFO with a valid/ready output.
module dcim_stream_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_COUNT = 64,
    parameter int ADDR_WIDTH = 6,
    parameter int MULT_WIDTH = 64,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  reload,
    input  logic [CNT_WIDTH-1:0]  num_ops,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  pe_ce,
    output logic                  init_enable,
    output logic [DATA_WIDTH-1:0] pe_data_in,
    input  logic                  pe_init_done,
    input  logic                  pe_valid_out,
    input  logic [MULT_WIDTH-1:0] pe_data_out,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [MULT_WIDTH-1:0] m_data,
    output logic                  m_last
);
    localparam int PTR_WIDTH  = $clog2(FIFO_DEPTH);
    localparam int FCNT_WIDTH = PTR_WIDTH + 1;
    localparam int SUM_WIDTH  = CNT_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LOAD_LAST  = ADDR_WIDTH'(ADDR_COUNT - 1);
    localparam logic [FCNT_WIDTH-1:0] FIFO_FULL  = FCNT_WIDTH'(FIFO_DEPTH);
    localparam logic [SUM_WIDTH-1:0]  CREDIT_CAP = SUM_WIDTH'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_LOAD_WAIT = 3'd2,
        ST_COMPUTE   = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [CNT_WIDTH-1:0]   num_ops_r;
    logic [CNT_WIDTH-1:0]   issued_r;
    logic [CNT_WIDTH-1:0]   received_r;
    logic [ADDR_WIDTH-1:0]  load_cnt_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   err_r;
    logic                   pe_ce_r;
    logic                   init_enable_r;
    logic [DATA_WIDTH-1:0]  pe_data_in_r;
    logic [MULT_WIDTH-1:0]  fifo_data_r [FIFO_DEPTH];
    logic                   fifo_last_r [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]   wr_ptr_r;
    logic [PTR_WIDTH-1:0]   rd_ptr_r;
    logic [FCNT_WIDTH-1:0]  fifo_cnt_r;

    logic [CNT_WIDTH-1:0]   inflight_s;
    logic [SUM_WIDTH-1:0]   occupancy_s;
    logic                   credit_ok_s;
    logic                   ready_s;
    logic                   hs_s;
    logic                   in_capture_s;
    logic                   counted_s;
    logic                   full_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   err_set_s;
    logic                   last_tag_s;
    logic                   m_valid_s;

    // Credit counts every outstanding compute result against FIFO space, so latency never overflows it
    assign inflight_s   = issued_r - received_r;
    assign occupancy_s  = SUM_WIDTH'(fifo_cnt_r) + SUM_WIDTH'(inflight_s);
    assign credit_ok_s  = occupancy_s < CREDIT_CAP;
    assign ready_s      = (state_r == ST_LOAD) ||
                          ((state_r == ST_COMPUTE) && credit_ok_s && (issued_r < num_ops_r));
    assign hs_s         = s_valid && ready_s;
    assign in_capture_s = (state_r == ST_COMPUTE) || (state_r == ST_DRAIN);
    assign counted_s    = pe_valid_out && in_capture_s && (inflight_s != {CNT_WIDTH{1'b0}});
    assign full_s       = (fifo_cnt_r == FIFO_FULL);
    assign m_valid_s    = (fifo_cnt_r != {FCNT_WIDTH{1'b0}});
    assign pop_s        = m_valid_s && m_ready;
    assign push_s       = counted_s && !full_s;
    assign err_set_s    = pe_valid_out && (!counted_s || full_s);
    assign last_tag_s   = (received_r == (num_ops_r - CNT_WIDTH'(1)));

    assign s_ready      = ready_s;
    assign busy         = busy_r;
    assign done         = done_r;
    assign err          = err_r;
    assign pe_ce        = pe_ce_r;
    assign init_enable  = init_enable_r;
    assign pe_data_in   = pe_data_in_r;
    assign m_valid      = m_valid_s;
    assign m_data       = m_valid_s ? fifo_data_r[rd_ptr_r] : {MULT_WIDTH{1'b0}};
    assign m_last       = m_valid_s ? fifo_last_r[rd_ptr_r] : 1'b0;

    // Sequencer next-state
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = reload ? ST_LOAD : ST_COMPUTE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (hs_s && (load_cnt_r == LOAD_LAST)) begin
                    state_nxt_s = ST_LOAD_WAIT;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_LOAD_WAIT: begin
                if (pe_init_done) begin
                    state_nxt_s = ST_COMPUTE;
                end else begin
                    state_nxt_s = ST_LOAD_WAIT;
                end
            end
            ST_COMPUTE: begin
                if (issued_r == num_ops_r) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_COMPUTE;
                end
            end
            ST_DRAIN: begin
                if (received_r == num_ops_r) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // State, sequence counters and status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            num_ops_r  <= {CNT_WIDTH{1'b0}};
            issued_r   <= {CNT_WIDTH{1'b0}};
            received_r <= {CNT_WIDTH{1'b0}};
            load_cnt_r <= {ADDR_WIDTH{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_DONE);
            done_r  <= (state_nxt_s == ST_DONE);
            err_r   <= err_r | err_set_s;
            if ((state_r == ST_IDLE) && start) begin
                num_ops_r  <= num_ops;
                issued_r   <= {CNT_WIDTH{1'b0}};
                received_r <= {CNT_WIDTH{1'b0}};
                load_cnt_r <= {ADDR_WIDTH{1'b0}};
            end else begin
                if (hs_s && (state_r == ST_LOAD)) begin
                    load_cnt_r <= load_cnt_r + ADDR_WIDTH'(1);
                end
                if (hs_s && (state_r == ST_COMPUTE)) begin
                    issued_r <= issued_r + CNT_WIDTH'(1);
                end
                if (counted_s) begin
                    received_r <= received_r + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Registered word strobe towards the macro; operand holds between issues
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pe_ce_r       <= 1'b0;
            init_enable_r <= 1'b0;
            pe_data_in_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            pe_ce_r       <= hs_s;
            init_enable_r <= hs_s && (state_r == ST_LOAD);
            if (hs_s) begin
                pe_data_in_r <= s_data;
            end
        end
    end

    // Result FIFO storage, kept free of reset so it maps onto plain registers/RAM
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_data_r[wr_ptr_r] <= pe_data_out;
            fifo_last_r[wr_ptr_r] <= last_tag_s;
        end
    end

    // Result FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r   <= {PTR_WIDTH{1'b0}};
            rd_ptr_r   <= {PTR_WIDTH{1'b0}};
            fifo_cnt_r <= {FCNT_WIDTH{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_WIDTH'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_WIDTH'(1);
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + FCNT_WIDTH'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - FCNT_WIDTH'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end
endmodule

// File: tb/tb_dcim_stream_sequencer.sv
// Randomized bench for dcim_stream_sequencer with a behavioural macro and a transaction-level
// scoreboard of expected issue words and result stream.
module tb_dcim_stream_sequencer;
    localparam int DW = 32;
    localparam int AC = 64;
    localparam int MW = 64;
    localparam int FD = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n, start, reload;
    logic [CW-1:0] num_ops;
    logic          busy, done, err, s_valid, s_ready;
    logic [DW-1:0] s_data;
    logic          pe_ce, init_enable;
    logic [DW-1:0] pe_data_in;
    logic          pe_init_done, pe_valid_out;
    logic [MW-1:0] pe_data_out;
    logic          m_valid, m_ready;
    logic [MW-1:0] m_data;
    logic          m_last;

    dcim_stream_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .reload(reload), .num_ops(num_ops),
        .busy(busy), .done(done), .err(err), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .pe_ce(pe_ce), .init_enable(init_enable), .pe_data_in(pe_data_in),
        .pe_init_done(pe_init_done), .pe_valid_out(pe_valid_out), .pe_data_out(pe_data_out),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    typedef struct { logic [MW-1:0] d; logic last; } res_t;
    typedef struct { int due; logic [MW-1:0] d; } pend_t;

    res_t          exp_q[$];
    pend_t         pend_q[$];
    logic [DW-1:0] weights [AC];
    int  checks = 0, errors = 0, cyc = 0;
    int  valid_pct = 100, mready_pct = 100, lat = 1;
    bit  valid_toggle = 1'b0;
    bit  req_start = 1'b0, req_reload = 1'b0;
    int  req_nops = 0;
    bit  inject = 1'b0;
    bit  model_busy = 1'b0, seq_done = 1'b0, await_init = 1'b0;
    int  load_left = 0, cur_nops = 0, comp_acc = 0, popped = 0, max_out = 0;
    int  init_cnt = 0, comp_ce_cnt = 0, last_cnt = 0, done_cnt = 0, seq_cycles = 0, done_at = 0;
    int  mac_load_idx = 0, mac_idx = 0;
    bit  exp_ce = 1'b0, exp_init = 1'b0;
    logic [DW-1:0] exp_data = '0;
    bit  hold_prev = 1'b0;
    logic [MW-1:0] hold_data = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: observe at the falling edge, then drive inputs for the next rising edge.
    task automatic step();
        bit            was_busy;
        res_t          r;
        pend_t         p;
        logic [MW-1:0] prod;
        @(negedge clk);
        cyc++;
        seq_cycles++;
        was_busy = model_busy;

        check_eq("pe_ce", 64'(pe_ce), 64'(exp_ce));
        if (pe_ce && exp_ce) begin
            check_eq("pe_data_in", 64'(pe_data_in), 64'(exp_data));
            check_eq("init_enable", 64'(init_enable), 64'(exp_init));
        end else if (!pe_ce) begin
            check_eq("init_idle", 64'(init_enable), 64'd0);
        end
        if (pe_ce && init_enable) init_cnt++;
        if (pe_ce && !init_enable) comp_ce_cnt++;

        if (done) begin
            if (!was_busy) check_eq("done_unexpected", 64'(done), 64'd0);
            done_cnt++;
            done_at = seq_cycles;
            check_eq("busy_at_done", 64'(busy), 64'd0);
            model_busy = 1'b0;
            seq_done = 1'b1;
        end else begin
            check_eq("busy", 64'(busy), 64'(model_busy));
        end

        if (hold_prev) begin
            check_eq("m_valid_hold", 64'(m_valid), 64'd1);
            check_eq("m_data_hold", m_data, hold_data);
        end
        m_ready = ($urandom_range(99) < mready_pct);
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_out", 64'(m_valid), 64'd0);
            end else begin
                r = exp_q.pop_front();
                check_eq("m_data", m_data, r.d);
                check_eq("m_last", 64'(m_last), 64'(r.last));
                popped++;
                if (m_last) last_cnt++;
            end
        end
        hold_prev = m_valid && !m_ready;
        hold_data = m_data;

        start = 1'b0;
        if (req_start) begin
            start = 1'b1;
            reload = req_reload;
            num_ops = CW'(req_nops);
            req_start = 1'b0;
            if (!was_busy) begin
                model_busy = 1'b1;
                seq_done = 1'b0;
                load_left = req_reload ? AC : 0;
                cur_nops = req_nops;
                comp_acc = 0;
                popped = 0;
                max_out = 0;
                await_init = 1'b0;
                mac_idx = 0;
            end
        end

        if (valid_toggle) s_valid = ((cyc % 2) == 0);
        else              s_valid = ($urandom_range(99) < valid_pct);
        s_data = $urandom;
        if (!was_busy) check_eq("ready_idle", 64'(s_ready), 64'd0);
        if (await_init) check_eq("ready_load_wait", 64'(s_ready), 64'd0);
        if (model_busy && load_left == 0 && !await_init && comp_acc >= cur_nops)
            check_eq("ready_after_last", 64'(s_ready), 64'd0);
        exp_ce = s_valid && s_ready;
        if (exp_ce) begin
            exp_data = s_data;
            if (load_left > 0) begin
                exp_init = 1'b1;
                load_left--;
                if (load_left == 0) await_init = 1'b1;
            end else begin
                exp_init = 1'b0;
                prod = {32'd0, s_data} * {32'd0, weights[comp_acc % AC]};
                exp_q.push_back('{prod, (comp_acc == cur_nops - 1)});
                comp_acc++;
            end
        end
        if (comp_acc - popped > max_out) max_out = comp_acc - popped;

        // Behavioural macro: stores load words, returns products after 'lat' cycles.
        pe_valid_out = 1'b0;
        pe_init_done = 1'b0;
        if (pe_ce && init_enable) begin
            weights[mac_load_idx] = pe_data_in;
            mac_load_idx++;
            if (mac_load_idx == AC) begin
                mac_load_idx = 0;
                pe_init_done = 1'b1;
                await_init = 1'b0;
            end
        end else if (pe_ce) begin
            pend_q.push_back('{cyc + lat - 1, {32'd0, pe_data_in} * {32'd0, weights[mac_idx % AC]}});
            mac_idx++;
        end
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            p = pend_q.pop_front();
            pe_valid_out = 1'b1;
            pe_data_out = p.d;
        end
        if (inject) begin
            pe_valid_out = 1'b1;
            pe_data_out = 64'hDEAD_BEEF_0BAD_F00D;
            inject = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        pe_valid_out = 1'b0; pe_init_done = 1'b0; req_start = 1'b0;
        exp_q.delete(); pend_q.delete();
        model_busy = 1'b0; seq_done = 1'b0; await_init = 1'b0; load_left = 0;
        cur_nops = 0; comp_acc = 0; popped = 0; exp_ce = 1'b0; hold_prev = 1'b0;
        mac_load_idx = 0; mac_idx = 0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_err", 64'(err), 64'd0);
        check_eq("rst_s_ready", 64'(s_ready), 64'd0);
        check_eq("rst_pe_ce", 64'(pe_ce), 64'd0);
        check_eq("rst_init_enable", 64'(init_enable), 64'd0);
        check_eq("rst_pe_data_in", 64'(pe_data_in), 64'd0);
        check_eq("rst_m_valid", 64'(m_valid), 64'd0);
        check_eq("rst_m_data", m_data, 64'd0);
        check_eq("rst_m_last", 64'(m_last), 64'd0);
    endtask

    task automatic start_seq(input bit rl, input int nops);
        req_start = 1'b1; req_reload = rl; req_nops = nops;
        init_cnt = 0; comp_ce_cnt = 0; last_cnt = 0; done_cnt = 0; seq_cycles = 0; done_at = 0;
        step();
    endtask

    task automatic finish_seq(input int budget);
        int n = 0;
        while (!(seq_done && exp_q.size() == 0) && n < budget) begin
            step();
            n++;
        end
        check_eq("seq_complete", 64'(seq_done && exp_q.size() == 0), 64'd1);
    endtask

    task automatic check_counts(input int loads, input int nops);
        check_eq("load_words", 64'(init_cnt), 64'(loads));
        check_eq("compute_words", 64'(comp_ce_cnt), 64'(nops));
        check_eq("last_count", 64'(last_cnt), 64'(nops > 0 ? 1 : 0));
        check_eq("done_count", 64'(done_cnt), 64'd1);
    endtask

    initial begin
        int n;
        for (int i = 0; i < AC; i++) weights[i] = DW'(i * 7 + 3);
        rst_n = 1'b0; start = 1'b0; reload = 1'b0; num_ops = '0; s_valid = 1'b0; s_data = '0;
        pe_init_done = 1'b0; pe_valid_out = 1'b0; pe_data_out = '0; m_ready = 1'b0;
        do_reset();

        // Full load followed by 64 compute words, no stalls.
        valid_pct = 100; mready_pct = 100; lat = 1;
        start_seq(1'b1, 64);
        finish_seq(1000);
        check_counts(64, 64);
        check_eq("err_full_run", 64'(err), 64'd0);

        // Downstream backpressure with 3-cycle macro latency.
        lat = 3; mready_pct = 0;
        start_seq(1'b0, 20);
        repeat (40) step();
        check_eq("bp_issued", 64'(comp_acc), 64'(FD));
        check_eq("bp_outstanding", 64'(max_out), 64'(FD));
        mready_pct = 100;
        finish_seq(500);
        check_counts(0, 20);
        check_eq("err_backpressure", 64'(err), 64'd0);

        // Upstream gaps.
        valid_toggle = 1'b1; lat = 2; mready_pct = 70;
        start_seq(1'b0, 10);
        finish_seq(500);
        check_counts(0, 10);
        valid_toggle = 1'b0;

        // Randomized sequences.
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 30);
            valid_pct = $urandom_range(30, 100);
            mready_pct = $urandom_range(20, 100);
            lat = $urandom_range(1, 5);
            start_seq(r == 2, n);
            finish_seq(3000);
            check_counts(r == 2 ? 64 : 0, n);
        end
        check_eq("err_random", 64'(err), 64'd0);

        // num_ops == 0, then start while busy.
        valid_pct = 100; mready_pct = 100; lat = 1;
        start_seq(1'b0, 0);
        finish_seq(20);
        check_eq("zero_ops_latency", 64'(done_at >= 2 && done_at <= 4), 64'd1);
        check_counts(0, 0);
        start_seq(1'b0, 12);
        repeat (4) step();
        req_start = 1'b1; req_reload = 1'b1; req_nops = 3;
        finish_seq(500);
        check_counts(0, 12);

        // Spurious result in IDLE, then extra result against a full FIFO.
        check_eq("err_before_inject", 64'(err), 64'd0);
        inject = 1'b1;
        repeat (2) step();
        check_eq("err_idle_inject", 64'(err), 64'd1);
        check_eq("idle_inject_dropped", 64'(m_valid), 64'd0);
        mready_pct = 0;
        start_seq(1'b0, FD);
        repeat (30) step();
        check_eq("full_seq_done", 64'(seq_done), 64'd1);
        check_eq("full_fifo_valid", 64'(m_valid), 64'd1);
        inject = 1'b1;
        repeat (2) step();
        mready_pct = 100;
        finish_seq(200);
        repeat (5) step();
        check_counts(0, FD);
        check_eq("err_sticky", 64'(err), 64'd1);

        // Reset in the middle of the load phase, then a clean run.
        start_seq(1'b1, 5);
        n = 0;
        while ((AC - load_left) < 30 && n < 200) begin
            step();
            n++;
        end
        check_eq("load_progress", 64'(AC - load_left), 64'd30);
        do_reset();
        check_eq("no_done_after_abort", 64'(done_cnt), 64'd0);
        start_seq(1'b1, 6);
        finish_seq(1000);
        check_counts(64, 6);
        check_eq("err_after_reset_run", 64'(err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dcim_stream_sequencer.md
Name: dcim_stream_sequencer

Overview:
Synthesizable host-side driver for sram_multiplier_system. It replaces bench stimulus with hardware sequencing. It accepts upstream operand words over valid/ready and runs the weight-load phase, then the compute phase. It collects pe_data_out results into a credit-protected FIFO with a downstream valid/ready stream.

Parameters:
DATA_WIDTH, 32, operand width
ADDR_COUNT, 64, SRAM words per load phase
ADDR_WIDTH, 6, log2(ADDR_COUNT)
MULT_WIDTH, 64, result width (2*DATA_WIDTH)
FIFO_DEPTH, 8, result FIFO entries (power of 2)
CNT_WIDTH, 16, width of compute-op counter

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle command pulse
reload  in  1  sampled at start; 1 = run load phase before compute
num_ops  in  CNT_WIDTH  compute words to issue, sampled at start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at sequence completion
err  out  1  sticky: result overflow or spurious result
s_valid  in  1  upstream operand valid
s_ready  out  1  upstream operand ready
s_data  in  DATA_WIDTH  upstream operand
pe_ce  out  1  word strobe to macro
init_enable  out  1  load-phase qualifier to macro
pe_data_in  out  DATA_WIDTH  operand to macro
pe_init_done  in  1  macro load complete
pe_valid_out  in  1  macro result valid
pe_data_out  in  MULT_WIDTH  macro result
m_valid  out  1  result stream valid
m_ready  in  1  result stream ready
m_data  out  MULT_WIDTH  result
m_last  out  1  marks result index num_ops-1

Behaviour:
- Clock is clk. Reset is rst_n, synchronous, active-low.
- Reset values: all outputs 0; state IDLE; FIFO empty; counters 0. Reset mid-sequence aborts immediately and flushes the FIFO. No done pulse is generated.
- States and transitions:
  - IDLE: on start, latch reload and num_ops. Go to LOAD if reload=1, else COMPUTE. start while busy is ignored.
  - LOAD: s_ready=1. Each s_valid&&s_ready handshake issues one word. After ADDR_COUNT words, go to LOAD_WAIT.
  - LOAD_WAIT: s_ready=0. Wait for pe_init_done=1, then go to COMPUTE.
  - COMPUTE: s_ready = (fifo_count + inflight < FIFO_DEPTH) && issued < num_ops. When issued == num_ops, go to DRAIN.
  - DRAIN: wait until received == num_ops, then go to DONE.
  - DONE: pulse done for 1 cycle, clear busy, go to IDLE.
  - num_ops==0: COMPUTE and DRAIN pass through in 1 cycle each. No words are issued.
- Issue timing: a handshake in cycle N drives registered outputs in cycle N+1.
  - pe_ce=1 and pe_data_in=s_data in that cycle.
  - init_enable=1 for load words, 0 for compute words.
  - pe_ce=0 and init_enable=0 in every non-issue cycle.
  - pe_data_in holds its last value when not issuing.
- Credit: inflight = issued - received, in compute phase only. Counters are CNT_WIDTH wide and do not wrap within a sequence. Credit guarantees FIFO capacity for every outstanding result, whatever the macro latency.
- Result capture: pe_valid_out in COMPUTE or DRAIN pushes pe_data_out and increments received. Same-cycle FIFO push and pop are both allowed; count is unchanged.
- Error conditions (each sets err, which is cleared only by reset):
  - pe_valid_out with the FIFO full: result dropped, received still increments.
  - pe_valid_out with inflight==0, or in IDLE/LOAD/LOAD_WAIT: ignored, not counted.
- FIFO pointers: ADDR-style binary, wrap modulo FIFO_DEPTH.
- Output stream:
  - m_valid = FIFO non-empty; m_data = head entry.
  - m_last is the tag stored at push: received index == num_ops-1.
  - Pop on m_valid&&m_ready.
  - m_data is stable while m_valid&&!m_ready.
- busy stays high until DONE, even if FIFO entries remain. Entries may drain after done.

Test Plan:
- Full load then compute: reload=1, num_ops=64, s_valid=1 constant, m_ready=1, model macro 1-cycle multiply with pe_init_done after 64th word. Expect 64 cycles init_enable=1, then 64 pe_ce strobes with init_enable=0, 64 results in order, m_last on result 63, done once, err=0.
- Backpressure: reload=0, num_ops=20, m_ready=0, macro latency 3. Expect issue stall with fifo_count+inflight=8, at most 8 words issued. Release m_ready: all 20 results arrive, none lost, err=0.
- Upstream gaps: s_valid toggling 1/0, 10 compute ops. Expect pe_ce only on handshake+1 cycles, pe_data_in matches accepted s_data.
- Boundary: num_ops=0 with reload=0. Expect done pulse within 3 cycles of start, no pe_ce. Also start while busy: ignored.
- Error: inject pe_valid_out in IDLE, and inject a push with the FIFO full via a forced extra result. Expect err=1 sticky, results ignored/dropped, received count correct.
- Reset mid-LOAD after 30 words: rst_n=0 for 1 cycle. Expect all outputs 0, FIFO empty, no done. A new start runs cleanly.
